// File: rtl/prog_loader.sv
// prog_loader: boot-time loader that turns a host word stream into cpu memory writes.
// The stream is a series of segments. Each segment is one header word and then N payload words.
// Header word layout: [31] target (0 imem / 1 dmem), [30] start, [29:16] base word addr, [15:0] N.
// After the segment flagged "start" completes, cpu_enable is held high until srst.
// Optional build macro PROG_LOADER_CHECKSUM_EN: a checksum word (the sum of the payload words) follows
// every segment with N > 0. A mismatch raises the sticky error flag and parks the loader in ERR.
module prog_loader #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_wen,
    output logic [DATA_W-1:0] imem_wdata,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic              dmem_wen,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic              cpu_enable,
    output logic              busy,
    output logic              error
);

    localparam int unsigned BASE_W = 14;

`ifdef PROG_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {ST_HEADER, ST_LOAD, ST_CHECK, ST_RUN, ST_ERR} state_t;
`else
    typedef enum logic [1:0] {ST_HEADER, ST_LOAD, ST_RUN} state_t;
`endif

    state_t            state;
    logic [BASE_W-1:0] waddr;
    logic [CNT_W-1:0]  remain;
    logic              target;
    logic              start;
    logic              fire;
    logic              hdr_target;
    logic              hdr_start;
    logic [BASE_W-1:0] hdr_base;
    logic [CNT_W-1:0]  hdr_cnt;
    logic [ADDR_W-1:0] byte_addr;

    // Decode the header fields and the handshake.
    assign fire       = s_valid & s_ready;
    assign hdr_target = s_data[31];
    assign hdr_start  = s_data[30];
    assign hdr_base   = s_data[29:16];
    assign hdr_cnt    = s_data[CNT_W-1:0];
    assign byte_addr  = ADDR_W'({waddr, 2'b00});

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum;
`else
    assign error = 1'b0;
`endif

    // Loader FSM. All outputs are registered. The write strobes default low every cycle.
    always_ff @(posedge clk) begin
        if (srst) begin
            state      <= ST_HEADER;
            s_ready    <= 1'b0;
            imem_addr  <= '0;
            imem_wen   <= 1'b0;
            imem_wdata <= '0;
            dmem_addr  <= '0;
            dmem_wen   <= 1'b0;
            dmem_wdata <= '0;
            cpu_enable <= 1'b0;
            busy       <= 1'b0;
            waddr      <= '0;
            remain     <= '0;
            target     <= 1'b0;
            start      <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum        <= '0;
            error      <= 1'b0;
`endif
        end else begin
            imem_wen <= 1'b0;
            dmem_wen <= 1'b0;
            case (state)
                ST_HEADER: begin
                    s_ready <= 1'b1;
                    if (fire) begin
                        target <= hdr_target;
                        start  <= hdr_start;
                        waddr  <= hdr_base;
                        remain <= hdr_cnt;
`ifdef PROG_LOADER_CHECKSUM_EN
                        sum    <= '0;
`endif
                        if (hdr_cnt != '0) begin
                            state <= ST_LOAD;
                            busy  <= 1'b1;
                        end else if (hdr_start) begin
                            // An empty start segment has no write in flight, so enable at once.
                            state      <= ST_RUN;
                            s_ready    <= 1'b0;
                            cpu_enable <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (fire) begin
                        if (target) begin
                            dmem_wen   <= 1'b1;
                            dmem_addr  <= byte_addr;
                            dmem_wdata <= s_data;
                        end else begin
                            imem_wen   <= 1'b1;
                            imem_addr  <= byte_addr;
                            imem_wdata <= s_data;
                        end
                        waddr  <= waddr + BASE_W'(1);
                        remain <= remain - CNT_W'(1);
`ifdef PROG_LOADER_CHECKSUM_EN
                        sum    <= sum + s_data;
                        if (remain == CNT_W'(1)) begin
                            state <= ST_CHECK;
                        end
`else
                        if (remain == CNT_W'(1)) begin
                            busy <= 1'b0;
                            if (start) begin
                                // cpu_enable follows in RUN, one cycle after this final write.
                                state   <= ST_RUN;
                                s_ready <= 1'b0;
                            end else begin
                                state <= ST_HEADER;
                            end
                        end
`endif
                    end
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    if (fire) begin
                        busy <= 1'b0;
                        if (s_data != sum) begin
                            state   <= ST_ERR;
                            s_ready <= 1'b0;
                            error   <= 1'b1;
                        end else if (start) begin
                            state      <= ST_RUN;
                            s_ready    <= 1'b0;
                            cpu_enable <= 1'b1;
                        end else begin
                            state <= ST_HEADER;
                        end
                    end
                end
                ST_ERR: begin
                    s_ready <= 1'b0;
                    busy    <= 1'b0;
                end
`endif
                ST_RUN: begin
                    s_ready    <= 1'b0;
                    busy       <= 1'b0;
                    cpu_enable <= 1'b1;
                end
                default: begin
                    state <= ST_HEADER;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader. Expected memory writes are queued as stimulus is issued.
// A negedge monitor pops and compares each write strobe it sees. Control outputs are checked inline.
// Supports both builds: with and without PROG_LOADER_CHECKSUM_EN.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        srst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = '0;
    logic [31:0] imem_addr;
    logic        imem_wen;
    logic [31:0] imem_wdata;
    logic [31:0] dmem_addr;
    logic        dmem_wen;
    logic [31:0] dmem_wdata;
    logic        cpu_enable;
    logic        busy;
    logic        error;

    typedef struct packed {
        logic        port;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t q[$];
    int  total = 0;
    int  bad = 0;

    prog_loader dut (
        .clk        (clk),
        .srst       (srst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .imem_addr  (imem_addr),
        .imem_wen   (imem_wen),
        .imem_wdata (imem_wdata),
        .dmem_addr  (dmem_addr),
        .dmem_wen   (dmem_wen),
        .dmem_wdata (dmem_wdata),
        .cpu_enable (cpu_enable),
        .busy       (busy),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_wr(input logic port, input logic [31:0] addr, input logic [31:0] data);
        wr_t e;
        e.port = port;
        e.addr = addr;
        e.data = data;
        q.push_back(e);
    endtask

    // Write monitor: every strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (imem_wen || dmem_wen) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: imem_wen=%b dmem_wen=%b imem_addr=%h dmem_addr=%h",
                         imem_wen, dmem_wen, imem_addr, dmem_addr);
            end else begin
                wr_t e;
                e = q.pop_front();
                chk("wr_both_ports", 32'(imem_wen & dmem_wen), 32'd0);
                chk("wr_enable_low", 32'(cpu_enable), 32'd0);
                chk("wr_port", 32'(dmem_wen), 32'(e.port));
                chk("wr_addr", e.port ? dmem_addr : imem_addr, e.addr);
                chk("wr_data", e.port ? dmem_wdata : imem_wdata, e.data);
            end
        end
    end

    // Drive one word (called at a negedge) and return at the negedge after it transfers.
    task automatic send(input logic [31:0] w);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = w;
        while (s_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (s_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL send_timeout: s_ready=%b want 1 for word %h", s_ready, w);
            s_valid = 1'b0;
        end else begin
            @(negedge clk);
            s_valid = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
        chk({tag, "_wen"}, 32'({imem_wen, dmem_wen}), 32'd0);
        chk({tag, "_imem_addr"}, imem_addr, 32'd0);
        chk({tag, "_dmem_addr"}, dmem_addr, 32'd0);
        chk({tag, "_imem_wdata"}, imem_wdata, 32'd0);
        chk({tag, "_dmem_wdata"}, dmem_wdata, 32'd0);
        chk({tag, "_cpu_enable"}, 32'(cpu_enable), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
    endtask

    task automatic do_reset();
        srst    = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        srst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 32'(s_ready), 32'd1);
    endtask

    // Close a segment. Send the checksum word when it is built in, then check the enable/ready state.
    task automatic end_seg(input logic [31:0] csum, input logic start);
`ifdef PROG_LOADER_CHECKSUM_EN
        send(csum);
        chk("seg_busy", 32'(busy), 32'd0);
        chk("seg_error", 32'(error), 32'd0);
        chk("seg_enable", 32'(cpu_enable), 32'(start));
        chk("seg_ready", 32'(s_ready), 32'(!start));
`else
        chk("seg_csum_unused", csum & 32'd0, 32'd0);
        chk("seg_busy", 32'(busy), 32'd0);
        chk("seg_enable_during_write", 32'(cpu_enable), 32'd0);
        if (start) begin
            @(negedge clk);
            chk("seg_enable", 32'(cpu_enable), 32'd1);
            chk("seg_ready", 32'(s_ready), 32'd0);
        end else begin
            chk("seg_ready", 32'(s_ready), 32'd1);
        end
`endif
    endtask

    task automatic hold_run(input int cycles);
        s_valid = 1'b1;
        s_data  = 32'h4000_0001;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            chk("run_ready", 32'(s_ready), 32'd0);
            chk("run_enable", 32'(cpu_enable), 32'd1);
            chk("run_busy", 32'(busy), 32'd0);
        end
        s_valid = 1'b0;
    endtask

    initial begin
        @(negedge clk);

        // Basic imem load with start.
        do_reset();
        expect_wr(1'b0, 32'h0, 32'h11);
        expect_wr(1'b0, 32'h4, 32'h22);
        expect_wr(1'b0, 32'h8, 32'h33);
        send(32'h4000_0003);
        chk("busy_in_load", 32'(busy), 32'd1);
        send(32'h11);
        send(32'h22);
        send(32'h33);
        end_seg(32'h66, 1'b1);
        hold_run(4);

        // dmem segment, then a back-to-back imem start segment.
        do_reset();
        expect_wr(1'b1, 32'h40, 32'hA);
        expect_wr(1'b1, 32'h44, 32'hB);
        expect_wr(1'b0, 32'h0, 32'hC);
        send(32'h8010_0002);
        send(32'hA);
        send(32'hB);
        end_seg(32'h15, 1'b0);
        send(32'h4000_0001);
        send(32'hC);
        end_seg(32'hC, 1'b1);

        // Base address wrap at the top of the 14-bit word space.
        do_reset();
        expect_wr(1'b0, 32'hFFFC, 32'h5);
        expect_wr(1'b0, 32'h0000, 32'h6);
        send(32'h7FFF_0002);
        send(32'h5);
        send(32'h6);
        end_seg(32'hB, 1'b1);

        // Stalls mid-payload: no writes in the gaps, address sequence continues.
        do_reset();
        expect_wr(1'b0, 32'h0, 32'h100);
        expect_wr(1'b0, 32'h4, 32'h200);
        expect_wr(1'b0, 32'h8, 32'h300);
        expect_wr(1'b0, 32'hC, 32'h400);
        send(32'h0000_0004);
        send(32'h100);
        @(negedge clk);
        @(negedge clk);
        chk("gap_busy", 32'(busy), 32'd1);
        send(32'h200);
        @(negedge clk);
        send(32'h300);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        send(32'h400);
        end_seg(32'hA00, 1'b0);
        chk("nostart_enable", 32'(cpu_enable), 32'd0);

        // Reset in the middle of a segment, then a normal segment.
        do_reset();
        expect_wr(1'b0, 32'h80, 32'hDEAD_0001);
        send(32'h0020_0004);
        send(32'hDEAD_0001);
        s_valid = 1'b1;
        s_data  = 32'hDEAD_0002;
        srst    = 1'b1;
        @(negedge clk);
        check_reset_outputs("midreset");
        srst    = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);
        chk("midreset_ready", 32'(s_ready), 32'd1);
        expect_wr(1'b0, 32'h0, 32'h99);
        send(32'h4000_0001);
        send(32'h99);
        end_seg(32'h99, 1'b1);

        // Empty start segment: enable on the next cycle, no writes.
        do_reset();
        send(32'h4000_0000);
        chk("empty_enable", 32'(cpu_enable), 32'd1);
        chk("empty_ready", 32'(s_ready), 32'd0);
        hold_run(5);

`ifdef PROG_LOADER_CHECKSUM_EN
        // Good checksum.
        do_reset();
        expect_wr(1'b0, 32'h0, 32'h1);
        expect_wr(1'b0, 32'h4, 32'h2);
        send(32'h4000_0002);
        send(32'h1);
        send(32'h2);
        end_seg(32'h3, 1'b1);

        // Bad checksum: sticky error, loader parked.
        do_reset();
        expect_wr(1'b0, 32'h0, 32'h1);
        expect_wr(1'b0, 32'h4, 32'h2);
        send(32'h4000_0002);
        send(32'h1);
        send(32'h2);
        send(32'h4);
        s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("err_flag", 32'(error), 32'd1);
            chk("err_enable", 32'(cpu_enable), 32'd0);
            chk("err_ready", 32'(s_ready), 32'd0);
            chk("err_busy", 32'(busy), 32'd0);
            @(negedge clk);
        end
        s_valid = 1'b0;
`endif

        @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global guard against a stuck run.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
